// File: rtl/mesh_boot_sequencer_if.sv
// Host, mesh-control and mesh-result signals of the boot sequencer.
// master = sequencer side, slave = host/mesh side.
interface mesh_boot_sequencer_if #(
    parameter int NUM_CORES  = 16,
    parameter int ID_BITS    = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  go;
    logic [NUM_CORES-1:0]  core_mask;
    logic [3:0]            operation;
    logic                  ON;
    logic [ID_BITS-1:0]    core_ID;
    logic                  core_reset;
    logic                  start;
    logic [31:0]           prog_address;
    logic [DATA_WIDTH-1:0] mesh_data;
    logic                  mesh_valid;
    logic                  mesh_ready;
    logic                  cmd;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  busy;
    logic                  done;
    logic [15:0]           drop_count;

    modport master (
        input  go, core_mask, mesh_data, mesh_valid, cmd,
        output operation, ON, core_ID, core_reset, start, prog_address,
               mesh_ready, data, valid, busy, done, drop_count
    );

    modport slave (
        output go, core_mask, mesh_data, mesh_valid, cmd,
        input  operation, ON, core_ID, core_reset, start, prog_address,
               mesh_ready, data, valid, busy, done, drop_count
    );
endinterface

// File: rtl/mesh_boot_sequencer.sv
// Boot scan (reset then start every masked core) plus result FIFO drained on cmd.
// Boot takes 1+SETTLE_CYC+2*NUM_CORES cycles; mesh_ready drops when full, drained words pop at most every 2nd cycle.
module mesh_boot_sequencer #(
    parameter int          NUM_CORES   = 16,
    parameter int          ID_BITS     = 4,
    parameter int          DATA_WIDTH  = 32,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] PROG_BASE   = 32'h10,
    parameter logic [31:0] PROG_STRIDE = 32'h10000,
    parameter int          SETTLE_CYC  = 1,
    parameter logic [3:0]  OP_RESET    = 4'b0011,
    parameter logic [3:0]  OP_START    = 4'b1010,
    parameter logic [3:0]  OP_IDLE     = 4'b0000
) (
    input  logic                   clock,
    input  logic                   RST,
    mesh_boot_sequencer_if.master  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_RSCAN  = 3'd2;
    localparam logic [2:0] S_SSCAN  = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;

    logic [2:0]           r_state;
    logic [ID_BITS-1:0]   r_idx;
    logic [SW-1:0]        r_settle;
    logic [NUM_CORES-1:0] r_mask;

    logic [3:0]           r_operation;
    logic                 r_on;
    logic [ID_BITS-1:0]   r_core_id;
    logic                 r_core_reset;
    logic                 r_start;
    logic [31:0]          r_prog_address;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_last_id;
    logic                 w_mask_bit;
    logic [31:0]          w_addr;

    assign w_last_id  = (r_idx == ID_BITS'(NUM_CORES - 1));
    assign w_mask_bit = r_mask[r_idx];
    assign w_addr     = PROG_BASE + 32'(r_idx) * PROG_STRIDE;

    always_ff @(posedge clock) begin
        if (!RST) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_settle       <= '0;
            r_mask         <= '0;
            r_operation    <= OP_IDLE;
            r_on           <= 1'b0;
            r_core_id      <= '0;
            r_core_reset   <= 1'b0;
            r_start        <= 1'b0;
            r_prog_address <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (bus.go) begin
                        r_state  <= S_SETTLE;
                        r_settle <= '0;
                        r_mask   <= bus.core_mask;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == SW'(SETTLE_CYC - 1)) begin
                        r_state <= S_RSCAN;
                        r_idx   <= '0;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                S_RSCAN: begin
                    r_idx <= w_last_id ? '0 : r_idx + 1'b1;
                    if (w_last_id) r_state <= S_SSCAN;
                end
                S_SSCAN: begin
                    r_idx <= w_last_id ? '0 : r_idx + 1'b1;
                    if (w_last_id) r_state <= S_RUN;
                end
                default: r_state <= S_IDLE;
            endcase

            // Outputs follow the state one cycle late; IDLE and SETTLE hold them.
            case (r_state)
                S_RSCAN: begin
                    r_on         <= 1'b1;
                    r_core_id    <= r_idx;
                    r_start      <= 1'b0;
                    r_core_reset <= w_mask_bit;
                    r_operation  <= w_mask_bit ? OP_RESET : OP_IDLE;
                end
                S_SSCAN: begin
                    r_core_id    <= r_idx;
                    r_core_reset <= 1'b0;
                    r_start      <= w_mask_bit;
                    r_operation  <= w_mask_bit ? OP_START : OP_IDLE;
                    if (w_mask_bit) r_prog_address <= w_addr;
                end
                S_RUN: begin
                    r_operation <= OP_IDLE;
                    r_start     <= 1'b0;
                end
                default: ;
            endcase

            r_busy <= (r_state == S_SETTLE) || (r_state == S_RSCAN) || (r_state == S_SSCAN);
            r_done <= (r_state == S_RUN);
        end
    end

    assign bus.operation    = r_operation;
    assign bus.ON           = r_on;
    assign bus.core_ID      = r_core_id;
    assign bus.core_reset   = r_core_reset;
    assign bus.start        = r_start;
    assign bus.prog_address = r_prog_address;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic                  r_rd_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic [15:0]           r_drop_count;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_drop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
    assign w_wr    = bus.mesh_valid && (!w_full || r_rd_en);
    assign w_drop  = bus.mesh_valid && w_full && !r_rd_en;

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= bus.mesh_data;
    end

    always_ff @(posedge clock) begin
        if (!RST) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_rd_en      <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            r_rd_en <= bus.cmd && !w_empty && !r_rd_en;
            r_valid <= r_rd_en;
            if (r_rd_en) begin
                r_data <= r_mem[r_rptr[AW-1:0]];
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign bus.mesh_ready = ~w_full;
    assign bus.data       = r_data;
    assign bus.valid      = r_valid;
    assign bus.drop_count = r_drop_count;
endmodule
